iob_clint_mt: RTL and testbench

Multi-hart, parametrised core-local interruptor (CLINT) for the IOb SoC, SiFive-compatible register map. It provides one 64-bit `mtime` counter advanced by an internal prescaler. Each hart gets a 64-bit `mtimecmp` register with a registered timer-interrupt output, and an `msip` software-interrupt bit. It sits on the native valid/ready peripheral bus. Beyond the previous generation it adds:
- 32- or 64-bit data bus
- byte-strobe writes
- an explicit one-cycle ready handshake
- tear-free 32-bit reads of `mtime`

---
 rtl/iob_clint_pkg.sv | 26 ++
 rtl/iob_clint_prescaler.sv | 27 ++
 rtl/iob_clint_mt.sv | 141 ++++++++++++++
 tb/tb_iob_clint_mt.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_clint_pkg.sv
// Shared constants and helpers for the multi-hart CLINT: register map bases,
// hart-index width and byte-lane merge used by every strobed register.
package iob_clint_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

  // Width of a hart index; never zero so a single-hart build still has a bit.
  function automatic int clint_hart_w(input int n_cores);
    return (n_cores > 1) ? $clog2(n_cores) : 1;
  endfunction

  // Replace the bytes of old_v whose strobe bit is set with the bytes of new_v.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iob_clint_prescaler.sv
// mtime prescaler: counts 0..PRESCALE-1 and pulses tick on the last count.
// A synchronous clear restarts the count (used when software rewrites mtime).
module iob_clint_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  // Free-running modulo-PRESCALE counter, restarted by reset or clear.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (tick)      count <= '0;
    else                count <= count + 1'b1;
  end

endmodule

// File: rtl/iob_clint_mt.sv
// Multi-hart CLINT on the native valid/ready bus: shared 64-bit mtime, one
// mtimecmp and one msip bit per hart, byte-strobed writes, 32/64-bit data bus
// and a shadowed mtime high word for tear-free 32-bit reads.
module iob_clint_mt
  import iob_clint_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_CORES  = 1,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic [N_CORES-1:0]    mtip,
  output logic [N_CORES-1:0]    msip
);

  localparam int              HART_W = clint_hart_w(N_CORES);
  localparam bit              WIDE   = (DATA_W == 64);
  localparam logic [11:0]     N_L    = 12'(N_CORES);

  // Register state
  logic [63:0] mtime;
  logic [63:0] mtimecmp [N_CORES];
  logic [31:0] shadow;
  logic        last_lo;

  // Decode
  logic [15:0]       addr16, msip_off, cmp_off;
  logic [11:0]       msip_idx, cmp_idx;
  logic [HART_W-1:0] msip_sel, cmp_sel;
  logic              is_msip, is_cmp, is_mtime, hi_word;
  logic              accept, is_write, mtime_wr, lo_rd, tick;

  assign addr16   = address[15:0];
  assign msip_off = addr16 - MSIP_BASE;
  assign cmp_off  = addr16 - MTIMECMP_BASE;
  assign msip_idx = msip_off[13:2];
  assign cmp_idx  = cmp_off[14:3];
  assign msip_sel = msip_idx[HART_W-1:0];
  assign cmp_sel  = cmp_idx[HART_W-1:0];
  assign hi_word  = addr16[2];

  assign is_msip  = (addr16 < MTIMECMP_BASE) && (msip_idx < N_L);
  assign is_cmp   = (addr16 >= MTIMECMP_BASE) && (addr16 < MTIME_BASE) && (cmp_idx < N_L);
  assign is_mtime = ((addr16 & 16'hFFF8) == MTIME_BASE);

  assign accept   = valid && !ready;
  assign is_write = |wstrb;
  assign mtime_wr = accept && is_write && is_mtime;
  assign lo_rd    = !is_write && is_mtime && !WIDE && !hi_word;

  logic unused_ok;
  assign unused_ok = ^{address, msip_off[15:14], msip_off[1:0], cmp_off[15], cmp_off[2:0]};

  // Lane-normalised write data/strobes and read data, always 64 bits wide
  logic [63:0]       wd64, rd64;
  logic [7:0]        ws64;
  logic              msip_bit, msip_ben;
  logic [DATA_W-1:0] rdata_next;

  // Map the bus lanes onto a 64-bit register view and build the read word.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    wd64 = '0;
    ws64 = '0;
    rd64 = '0;
    if (WIDE) begin
      wd64 = 64'(wdata);
      ws64 = 8'(wstrb);
    end else begin
      wd64 = {2{wdata[31:0]}};
      ws64 = hi_word ? {wstrb[3:0], 4'b0000} : {4'b0000, wstrb[3:0]};
    end
    msip_bit = hi_word ? wd64[32] : wd64[0];
    msip_ben = hi_word ? ws64[4]  : ws64[0];

    if (is_msip) begin
      rd64 = hi_word ? {31'b0, msip[msip_sel], 32'b0} : {63'b0, msip[msip_sel]};
    end else if (is_cmp) begin
      rd64 = mtimecmp[cmp_sel];
    end else if (is_mtime) begin
      rd64 = mtime;
      if (!WIDE && hi_word && last_lo) rd64[63:32] = shadow;
    end

    if (WIDE) rdata_next = DATA_W'(rd64);
    else      rdata_next = DATA_W'(hi_word ? rd64[63:32] : rd64[31:0]);
  end

  iob_clint_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(mtime_wr),
    .tick (tick)
  );

  // Handshake, register file, shadow and mtime updates at the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready   <= 1'b0;
      rdata   <= '0;
      msip    <= '0;
      shadow  <= '0;
      last_lo <= 1'b0;
      mtime   <= '0;
      // NOTE: mtimecmp is a register file with a defined reset value, so it is reset entry by entry.
      for (int h = 0; h < N_CORES; h++) mtimecmp[h] <= '1;
    end else begin
      ready <= accept;
      if (accept) begin
        last_lo <= lo_rd;
        if (!is_write) rdata <= rdata_next;
        if (lo_rd) shadow <= mtime[63:32];
        if (is_write && is_msip && msip_ben) msip[msip_sel] <= msip_bit;
        if (is_write && is_cmp)
          mtimecmp[cmp_sel] <= merge_bytes(mtimecmp[cmp_sel], wd64, ws64);
      end
      if (mtime_wr)  mtime <= merge_bytes(mtime, wd64, ws64);
      else if (tick) mtime <= mtime + 64'd1;
    end
  end

  // Registered timer interrupt per hart: unsigned 64-bit compare every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtip <= '0;
    end else begin
      for (int h = 0; h < N_CORES; h++) mtip[h] <= (mtime >= mtimecmp[h]);
    end
  end

endmodule

// File: tb/tb_iob_clint_mt.sv
// Self-checking bench for iob_clint_mt (DATA_W=32, N_CORES=3, PRESCALE=4):
// requests push expected responses into a scoreboard, a monitor pops them on
// ready, and an interrupt checker compares mtip/msip against the model each cycle.
module tb_iob_clint_mt;

  localparam int P  = 4;
  localparam int NC = 3;
  localparam int K_NONE = 0, K_MSIP = 1, K_CMP = 2, K_TIME = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [NC-1:0] mtip, msip;

  iob_clint_mt #(
    .ADDR_W(32), .DATA_W(32), .N_CORES(NC), .PRESCALE(P)
  ) dut (
    .clk(clk), .reset(reset), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .mtip(mtip), .msip(msip)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (request-level) ----------------
  logic [63:0] m_base;
  int          m_wcyc;
  logic [63:0] m_cmp [NC];
  logic [NC-1:0] m_msip;
  logic [31:0] m_shadow;
  bit          m_last_lo;

  // mtime after edge n: base plus one per P edges since the last write/reset.
  function automatic logic [63:0] m_time(input int n);
    return m_base + 64'((n - m_wcyc) / P);
  endfunction

  function automatic logic [63:0] m_merge(input logic [63:0] v, input bit hi,
                                          input logic [31:0] d, input logic [3:0] s);
    logic [63:0] r;
    r = v;
    for (int i = 0; i < 4; i++) if (s[i]) r[(hi ? 32 : 0) + i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_base = '0;
    m_wcyc = cyc;
    for (int h = 0; h < NC; h++) m_cmp[h] = '1;
    m_msip = '0;
    m_shadow = '0;
    m_last_lo = 0;
  endtask

  task automatic decode(input logic [15:0] o, output int kind, output int h);
    kind = K_NONE;
    h = 0;
    if (int'(o) < 'h4000) begin
      h = int'(o) / 4;
      if (h < NC) kind = K_MSIP;
    end else if (int'(o) < 'hBFF8) begin
      h = (int'(o) - 'h4000) / 8;
      if (h < NC) kind = K_CMP;
    end else if (int'(o) < 'hC000) begin
      kind = K_TIME;
    end
  endtask

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];
  int   pulses = 0;
  logic ready_prev = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (ready) begin
      pulses++;
      if (ready_prev) begin
        checks++; errors++;
        $display("FAIL ready_width got=2+ cycles exp=1 cycle (t=%0t)", $time);
      end
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ready_unexpected got=ready exp=no pending request (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_rd) check($sformatf("rdata@%h", mon_e.addr), 64'(rdata), 64'(mon_e.data));
      end
    end
    ready_prev = ready;
  end

  // ---------------- interrupt checker ----------------
  bit          chk_en = 0;
  logic [63:0] p_time;
  logic [63:0] p_cmp [NC];
  logic [NC-1:0] exp_mtip;

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      for (int h = 0; h < NC; h++) exp_mtip[h] = (p_time >= p_cmp[h]);
      check("mtip", 64'(mtip), 64'(exp_mtip));
      check("msip", 64'(msip), 64'(m_msip));
    end
    p_time = m_time(cyc);
    for (int h = 0; h < NC; h++) p_cmp[h] = m_cmp[h];
  end

  // ---------------- stimulus ----------------
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int kind, h;
    bit hi;
    logic [15:0] o;
    logic [63:0] cur;
    logic [31:0] rv;
    @(negedge clk);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    o = a[15:0];
    hi = o[2];
    cur = m_time(cyc);
    decode(o, kind, h);
    rv = '0;
    case (kind)
      K_MSIP: rv = {31'b0, m_msip[h]};
      K_CMP:  rv = hi ? m_cmp[h][63:32] : m_cmp[h][31:0];
      K_TIME: rv = hi ? (m_last_lo ? m_shadow : cur[63:32]) : cur[31:0];
      default: rv = '0;
    endcase
    e.is_rd = (s == 4'b0000);
    e.addr = a;
    e.data = rv;
    sb_q.push_back(e);
    @(negedge clk);
    valid = 1'b0; wstrb = '0;
    if (s == 4'b0000) begin
      if (kind == K_TIME && !hi) m_shadow = cur[63:32];
      m_last_lo = (kind == K_TIME && !hi);
    end else begin
      m_last_lo = 0;
      case (kind)
        K_MSIP: if (s[0]) m_msip[h] = d[0];
        K_CMP:  m_cmp[h] = m_merge(m_cmp[h], hi, d, s);
        K_TIME: begin m_base = m_merge(cur, hi, d, s); m_wcyc = cyc; end
        default: ;
      endcase
    end
    #1;
    check("ready_latency", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic hold4();
    exp_t e;
    int c0;
    @(negedge clk);
    c0 = pulses;
    valid = 1'b1; address = 32'h0000_4000; wdata = '0; wstrb = '0;
    e.is_rd = 1; e.addr = 32'h0000_4000; e.data = m_cmp[0][31:0];
    sb_q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    sb_q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    valid = 1'b0;
    m_last_lo = 0;
    @(negedge clk);
    #1;
    check("hold_pulses", 64'(pulses - c0), 64'd2);
  endtask

  logic [15:0] unmapped [5] = '{16'h3FFC, 16'hBFF0, 16'hC000, 16'hFFFC, 16'h2000};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_mtip",  64'(mtip),  64'd0);
    check("rst_msip",  64'(msip),  64'd0);
    @(negedge clk);
    chk_en = 1;

    // reset value of mtimecmp
    req(32'h0000_4000, 0, 4'b0000);

    // carry into the high word across prescaled ticks
    req(32'h0000_BFFC, 32'h0, 4'hF);
    req(32'h0000_BFF8, 32'hFFFF_FFFE, 4'hF);
    repeat (8) @(negedge clk);
    req(32'h0000_BFF8, 0, 4'b0000);
    req(32'h0000_BFFC, 0, 4'b0000);

    // tear-free read across a low-word wrap, then a live high read
    req(32'h0000_BFFC, 32'h0, 4'hF);
    req(32'h0000_BFF8, 32'hFFFF_FFFA, 4'hF);
    req(32'h0000_BFF8, 0, 4'b0000);
    repeat (40) @(negedge clk);
    req(32'h0000_BFFC, 0, 4'b0000);
    req(32'h0000_BFFC, 0, 4'b0000);

    // hart 2 timer compare at 100
    req(32'h0000_BFFC, 32'h0, 4'hF);
    req(32'h0000_BFF8, 32'h0, 4'hF);
    req(32'h0000_4014, 32'h0, 4'hF);
    req(32'h0000_4010, 32'd100, 4'hF);
    repeat (420) @(negedge clk);
    #3;
    check("mtip_hart2", 64'(mtip), 64'b100);

    // software interrupt bit and out-of-range hart
    req(32'h0000_0004, 32'hFFFF_FFFF, 4'hF);
    req(32'h0000_0004, 0, 4'b0000);
    req(32'h0000_0014, 32'hFFFF_FFFF, 4'hF);
    req(32'h0000_0014, 0, 4'b0000);

    // single-byte strobe into mtimecmp[0] low
    req(32'h0000_4000, 32'h0000_AB00, 4'b0010);
    req(32'h0000_4000, 0, 4'b0000);

    // valid held for 4 cycles
    hold4();

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      int kind, h, w;
      logic [15:0] o;
      logic [31:0] d;
      logic [3:0]  s;
      logic [63:0] now;
      kind = $urandom_range(0, 3);
      h = $urandom_range(0, 4);
      w = $urandom_range(0, 1);
      now = m_time(cyc);
      case (kind)
        0: begin o = 16'(h * 4);                 d = $urandom; end
        1: begin o = 16'('h4000 + h * 8 + w * 4); d = w ? 32'h0 : now[31:0] + $urandom_range(0, 30); end
        2: begin o = 16'('hBFF8 + w * 4);          d = w ? 32'h0 : $urandom_range(0, 200); end
        default: begin o = unmapped[$urandom_range(0, 4)]; d = $urandom; end
      endcase
      s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      req({16'($urandom), o}, d, s);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset sampled together with a request: no ready, no write
    chk_en = 0;
    @(negedge clk);
    reset = 1'b1; valid = 1'b1; address = 32'h0000_4000; wdata = 32'h0; wstrb = 4'hF;
    @(negedge clk);
    valid = 1'b0; wstrb = '0;
    check("rst_drop_ready", 64'(ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk_en = 1;
    req(32'h0000_4000, 0, 4'b0000);
    req(32'h0000_0004, 0, 4'b0000);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
